// File: rtl/serial_palindrome_checker.sv
// serial_palindrome_checker
//   Takes in a 1-bit stream, MSB first, and builds DATA_WIDTH-bit words from it.
//   Each finished word is checked to see whether it is a palindrome.
//   The word and its flag are then offered on a registered valid/ready output.
//   The shift register and the output register are separate, so the next word
//   can be collected while the current one is still waiting to be taken.
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   din        : serial data bit (the first bit of a word becomes its MSB)
//   din_valid  : din carries a valid bit this cycle
//   din_ready  : block accepts din this cycle
//   dout       : assembled word
//   dout_pal   : 1 when dout is a palindrome
//   dout_valid : dout/dout_pal are valid; they stay stable until accepted
//   dout_ready : consumer accepts the word
//   pal_count  : saturating count of palindromic words loaded to the output
module serial_palindrome_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_pal,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [CNT_WIDTH-1:0]  pal_count
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] FULL_CNT = BW'(DATA_WIDTH);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] sreg, sreg_nxt, shifted, load_word, dout_nxt;
    logic [BW-1:0]         bit_cnt, cnt_nxt;
    logic                  pal_nxt, valid_nxt, load, out_free;
    logic [CNT_WIDTH-1:0]  count_nxt;

    // The middle bit of an odd-length word is never compared; for a 1-bit word
    // the loop does not run, so the result is always 1.
    function automatic logic is_pal(input logic [DATA_WIDTH-1:0] w);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < DATA_WIDTH / 2; i++)
            r &= (w[i] == w[DATA_WIDTH-1-i]);
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = bit_cnt;
        dout_nxt  = dout;
        pal_nxt   = dout_pal;
        valid_nxt = dout_valid;
        count_nxt = pal_count;
        load      = 1'b0;
        load_word = '0;
        din_ready = (state == COLLECT);
        out_free  = !dout_valid || dout_ready;
        // Truncating the concatenation drops the old MSB. This still works
        // when DATA_WIDTH is 1.
        shifted   = DATA_WIDTH'({sreg, din});

        if (dout_valid && dout_ready)
            valid_nxt = 1'b0;

        case (state)
            COLLECT: begin
                if (din_valid) begin
                    sreg_nxt = shifted;
                    if (bit_cnt == LAST) begin
                        if (out_free) begin
                            load      = 1'b1;
                            load_word = shifted;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt   = FULL_CNT;
                            state_nxt = FULL;
                        end
                    end else begin
                        cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (dout_valid && dout_ready) begin
                    load      = 1'b1;
                    load_word = sreg;
                    cnt_nxt   = '0;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase

        // A load on the same edge as a consume overrides the clear of valid.
        if (load) begin
            dout_nxt  = load_word;
            pal_nxt   = is_pal(load_word);
            valid_nxt = 1'b1;
            if (pal_nxt && (pal_count != '1))
                count_nxt = pal_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_pal   <= 1'b0;
            dout_valid <= 1'b0;
            pal_count  <= '0;
        end else begin
            sreg       <= sreg_nxt;
            bit_cnt    <= cnt_nxt;
            dout       <= dout_nxt;
            dout_pal   <= pal_nxt;
            dout_valid <= valid_nxt;
            pal_count  <= count_nxt;
        end
    end

endmodule

// File: tb/tb_serial_palindrome_checker.sv
module tb_serial_palindrome_checker;

    typedef struct {
        logic [7:0]  w;
        logic        p;
        logic [15:0] c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    exp_t q8[$];
    exp_t q5[$];

    // DW=8, CNT_WIDTH=2 instance
    logic       rst8, din8, din_valid8, din_ready8, dout_pal8, dout_valid8, dout_ready8;
    logic [7:0] dout8;
    logic [1:0] pal_count8;

    // DW=5, CNT_WIDTH=16 instance
    logic        rst5, din5, din_valid5, din_ready5, dout_pal5, dout_valid5, dout_ready5;
    logic [4:0]  dout5;
    logic [15:0] pal_count5;

    serial_palindrome_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u8 (
        .clk(clk), .reset(rst8), .din(din8), .din_valid(din_valid8), .din_ready(din_ready8),
        .dout(dout8), .dout_pal(dout_pal8), .dout_valid(dout_valid8),
        .dout_ready(dout_ready8), .pal_count(pal_count8)
    );

    serial_palindrome_checker #(.DATA_WIDTH(5), .CNT_WIDTH(16)) u5 (
        .clk(clk), .reset(rst5), .din(din5), .din_valid(din_valid5), .din_ready(din_ready5),
        .dout(dout5), .dout_pal(dout_pal5), .dout_valid(dout_valid5),
        .dout_ready(dout_ready5), .pal_count(pal_count5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    // Monitors: a word is taken when valid & ready are both high at the falling edge.
    always @(negedge clk) begin
        if (!rst8 && dout_valid8 && dout_ready8) begin
            if (q8.size() == 0) begin
                chk("u8_unexpected_word", {24'd0, dout8}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("u8_dout", {24'd0, dout8}, {24'd0, e.w});
                chk("u8_pal", {31'd0, dout_pal8}, {31'd0, e.p});
                chk("u8_count", {30'd0, pal_count8}, {16'd0, e.c});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst5 && dout_valid5 && dout_ready5) begin
            if (q5.size() == 0) begin
                chk("u5_unexpected_word", {27'd0, dout5}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q5.pop_front();
                chk("u5_dout", {27'd0, dout5}, {24'd0, e.w});
                chk("u5_pal", {31'd0, dout_pal5}, {31'd0, e.p});
                chk("u5_count", {16'd0, pal_count5}, {16'd0, e.c});
            end
        end
    end

    int rdy_drop = 0;

    task automatic send8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            din8 = w[i];
            din_valid8 = 1'b1;
            if (!din_ready8) rdy_drop++;
            @(posedge clk); #1;
        end
    endtask

    task automatic send5(input logic [4:0] w);
        for (int i = 4; i >= 0; i--) begin
            din5 = w[i];
            din_valid5 = 1'b1;
            @(posedge clk); #1;
        end
        din_valid5 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst8 = 1'b1; rst5 = 1'b1;
        din8 = 1'b0; din_valid8 = 1'b0; dout_ready8 = 1'b1;
        din5 = 1'b0; din_valid5 = 1'b0; dout_ready5 = 1'b1;
        #1;
        chk("rst_dout", {24'd0, dout8}, 32'd0);
        chk("rst_valid", {31'd0, dout_valid8}, 32'd0);
        chk("rst_pal", {31'd0, dout_pal8}, 32'd0);
        chk("rst_count", {30'd0, pal_count8}, 32'd0);
        idle(2);
        rst8 = 1'b0; rst5 = 1'b0;
        chk("rst_din_ready", {31'd0, din_ready8}, 32'd1);

        // A5 arrives one cycle after its last bit
        q8.push_back('{w: 8'hA5, p: 1'b1, c: 16'd1});
        send8(8'hA5);
        din_valid8 = 1'b0;
        chk("latency_valid", {31'd0, dout_valid8}, 32'd1);
        chk("latency_dout", {24'd0, dout8}, 32'hA5);
        idle(2);

        // Back-to-back words with no gap
        rdy_drop = 0;
        q8.push_back('{w: 8'h01, p: 1'b0, c: 16'd1});
        q8.push_back('{w: 8'h81, p: 1'b1, c: 16'd2});
        send8(8'h01);
        send8(8'h81);
        din_valid8 = 1'b0;
        chk("stream_din_ready_drops", rdy_drop, 32'd0);
        idle(2);

        // Backpressure: second word parks in FULL
        dout_ready8 = 1'b0;
        q8.push_back('{w: 8'h3C, p: 1'b1, c: 16'd3});
        q8.push_back('{w: 8'h5A, p: 1'b1, c: 16'd3});
        send8(8'h3C);
        send8(8'h5A);
        din_valid8 = 1'b0;
        chk("full_din_ready", {31'd0, din_ready8}, 32'd0);
        idle(3);
        chk("full_hold_dout", {24'd0, dout8}, 32'h3C);
        chk("full_hold_din_ready", {31'd0, din_ready8}, 32'd0);
        dout_ready8 = 1'b1;
        @(posedge clk); #1;
        dout_ready8 = 1'b0;
        chk("full_next_dout", {24'd0, dout8}, 32'h5A);
        chk("full_next_valid", {31'd0, dout_valid8}, 32'd1);
        chk("full_after_din_ready", {31'd0, din_ready8}, 32'd1);
        idle(2);
        dout_ready8 = 1'b1;
        idle(2);

        // Reset in the middle of a word while the output is occupied
        dout_ready8 = 1'b0;
        send8(8'h00);
        din8 = 1'b1;
        idle(3);
        din_valid8 = 1'b0;
        chk("pre_rst_valid", {31'd0, dout_valid8}, 32'd1);
        rst8 = 1'b1;
        #1;
        chk("mid_rst_dout", {24'd0, dout8}, 32'd0);
        chk("mid_rst_valid", {31'd0, dout_valid8}, 32'd0);
        chk("mid_rst_count", {30'd0, pal_count8}, 32'd0);
        @(posedge clk); #1;
        rst8 = 1'b0;
        chk("mid_rst_din_ready", {31'd0, din_ready8}, 32'd1);
        dout_ready8 = 1'b1;
        q8.push_back('{w: 8'hE7, p: 1'b1, c: 16'd1});
        send8(8'hE7);
        din_valid8 = 1'b0;
        idle(3);

        // Counter saturation (2-bit)
        rst8 = 1'b1;
        idle(1);
        rst8 = 1'b0;
        q8.push_back('{w: 8'h81, p: 1'b1, c: 16'd1});
        q8.push_back('{w: 8'hFF, p: 1'b1, c: 16'd2});
        q8.push_back('{w: 8'h00, p: 1'b1, c: 16'd3});
        q8.push_back('{w: 8'h18, p: 1'b1, c: 16'd3});
        q8.push_back('{w: 8'h66, p: 1'b1, c: 16'd3});
        send8(8'h81);
        send8(8'hFF);
        send8(8'h00);
        send8(8'h18);
        send8(8'h66);
        din_valid8 = 1'b0;
        idle(2);

        // Odd width: the middle bit is ignored; a pause mid-word keeps partial bits
        q5.push_back('{w: 8'h1B, p: 1'b1, c: 16'd1});
        q5.push_back('{w: 8'h11, p: 1'b1, c: 16'd2});
        q5.push_back('{w: 8'h15, p: 1'b1, c: 16'd3});
        q5.push_back('{w: 8'h1A, p: 1'b0, c: 16'd3});
        q5.push_back('{w: 8'h01, p: 1'b0, c: 16'd3});
        din5 = 1'b1; din_valid5 = 1'b1;
        idle(2);
        din_valid5 = 1'b0;
        idle(3);
        din5 = 1'b0; din_valid5 = 1'b1;
        idle(1);
        din5 = 1'b1;
        idle(2);
        din_valid5 = 1'b0;
        idle(1);
        send5(5'b10001);
        send5(5'b10101);
        send5(5'b11010);
        send5(5'b00001);
        idle(2);

        for (int n = 0; n < 100 && (q8.size() != 0 || q5.size() != 0); n++) idle(1);
        chk("u8_queue_drained", q8.size(), 32'd0);
        chk("u5_queue_drained", q5.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
